// File: rtl/gcd_dispatcher.sv
// Operand-pair FIFO feeding a non-pipelined GCD engine; one job in flight,
// results returned in push order with their tag on a valid/ready port.
module gcd_dispatcher #(
  parameter int BIT_LEN    = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4
) (
  input  logic               clk_i,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BIT_LEN-1:0] in_num_0,
  input  logic [BIT_LEN-1:0] in_num_1,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               gcd_start,
  output logic [BIT_LEN-1:0] gcd_num_0,
  output logic [BIT_LEN-1:0] gcd_num_1,
  input  logic               gcd_busy,
  input  logic               gcd_done,
  input  logic [BIT_LEN-1:0] gcd_result,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [BIT_LEN-1:0] res_gcd,
  output logic [TAG_W-1:0]   res_tag,
  output logic               idle
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [BIT_LEN-1:0] num_0;
    logic [BIT_LEN-1:0] num_1;
    logic [TAG_W-1:0]   tag;
  } entry_t;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  entry_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  state_t             state;
  logic [TAG_W-1:0]   active_tag;

  logic   full;
  logic   empty;
  logic   push;
  logic   slot_free;
  logic   issue;
  logic   capture;
  entry_t head;

  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign push      = in_valid & ~full;
  // The result slot counts as free when its current result leaves this cycle.
  assign slot_free = ~res_valid | res_ready;
  assign issue     = (state == S_IDLE) & ~empty & slot_free & ~gcd_busy;
  assign capture   = (state == S_WAIT) & gcd_done;
  assign head      = empty ? '0 : mem[rd_ptr];

  assign in_ready  = ~full;
  assign gcd_start = issue;
  assign gcd_num_0 = head.num_0;
  assign gcd_num_1 = head.num_1;
  assign idle      = empty & (state == S_IDLE) & ~res_valid;

  // NOTE: FIFO storage has no reset; pointers and count alone say which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= '{num_0: in_num_0, num_1: in_num_1, tag: in_tag};
  end

  // NOTE: all state here uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      state      <= S_IDLE;
      active_tag <= '0;
      res_valid  <= 1'b0;
      res_gcd    <= '0;
      res_tag    <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      case ({push, issue})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      case (state)
        S_IDLE: begin
          // A done pulse seen here is stray and deliberately ignored.
          if (issue) begin
            active_tag <= head.tag;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (gcd_done) begin
            res_gcd <= gcd_result;
            res_tag <= active_tag;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (capture)                    res_valid <= 1'b1;
      else if (res_valid & res_ready) res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gcd_dispatcher.sv
// Bench for gcd_dispatcher: emulated GCD engine, queue-based reference model
// compared every cycle, directed scenarios with literal expectations, random traffic.
module tb_gcd_dispatcher;

  localparam int BIT_LEN    = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int TAG_W      = 4;

  logic               clk_i = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [BIT_LEN-1:0] in_num_0 = '0;
  logic [BIT_LEN-1:0] in_num_1 = '0;
  logic [TAG_W-1:0]   in_tag = '0;
  logic               gcd_start;
  logic [BIT_LEN-1:0] gcd_num_0;
  logic [BIT_LEN-1:0] gcd_num_1;
  logic               gcd_busy = 1'b0;
  logic               gcd_done = 1'b0;
  logic [BIT_LEN-1:0] gcd_result = '0;
  logic               res_valid;
  logic               res_ready = 1'b0;
  logic [BIT_LEN-1:0] res_gcd;
  logic [TAG_W-1:0]   res_tag;
  logic               idle;

  gcd_dispatcher #(
    .BIT_LEN(BIT_LEN), .FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W)
  ) dut (
    .clk_i(clk_i), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_num_0(in_num_0), .in_num_1(in_num_1), .in_tag(in_tag),
    .gcd_start(gcd_start), .gcd_num_0(gcd_num_0), .gcd_num_1(gcd_num_1),
    .gcd_busy(gcd_busy), .gcd_done(gcd_done), .gcd_result(gcd_result),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_gcd(res_gcd), .res_tag(res_tag), .idle(idle)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [BIT_LEN-1:0] a;
    logic [BIT_LEN-1:0] b;
    logic [TAG_W-1:0]   tag;
  } pair_t;

  typedef struct {
    logic [BIT_LEN-1:0] g;
    logic [TAG_W-1:0]   tag;
  } res_t;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // Reference model state: pending pairs, in-flight job, result slot, expected result order.
  pair_t              mq[$];
  res_t               oq[$];
  bit                 m_inflight = 1'b0;
  bit                 m_rv = 1'b0;
  logic [BIT_LEN-1:0] m_rgcd = '0;
  logic [TAG_W-1:0]   m_rtag = '0;
  logic [TAG_W-1:0]   m_atag = '0;

  // Emulated engine state and its outputs for the next cycle.
  int                 eng_left = 0;
  logic [BIT_LEN-1:0] eng_res = '0;
  logic               eng_busy_n = 1'b0;
  logic               eng_done_n = 1'b0;
  logic [BIT_LEN-1:0] eng_res_n = '0;
  bit                 stray_req = 1'b0;
  bit                 long_lat = 1'b0;

  function automatic logic [BIT_LEN-1:0] ref_gcd(input logic [BIT_LEN-1:0] a,
                                                 input logic [BIT_LEN-1:0] b);
    int x = int'(a);
    int y = int'(b);
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return BIT_LEN'(x);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_in(input bit v, input logic [BIT_LEN-1:0] a,
                        input logic [BIT_LEN-1:0] b, input logic [TAG_W-1:0] t);
    in_valid = v;
    in_num_0 = a;
    in_num_1 = b;
    in_tag   = t;
  endtask

  task automatic wait_res(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk_i);
      if (res_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk_i);
      if (idle === 1'b1 && eng_left == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Engine outputs change just after the rising edge, like any other input.
  always @(posedge clk_i) begin
    #1;
    gcd_busy   = eng_busy_n;
    gcd_done   = eng_done_n;
    gcd_result = eng_res_n;
  end

  // Per-cycle compare, then advance the model and the engine to the next edge.
  always @(negedge clk_i) begin
    bit                 exp_start;
    bit                 do_push;
    pair_t              p;
    res_t               r;
    int                 lat;
    logic [BIT_LEN-1:0] h0;
    logic [BIT_LEN-1:0] h1;

    exp_start = !m_inflight && mq.size() > 0 && (!m_rv || res_ready === 1'b1) && gcd_busy === 1'b0;
    h0 = (mq.size() > 0) ? mq[0].a : '0;
    h1 = (mq.size() > 0) ? mq[0].b : '0;

    if (chk_en) begin
      check("in_ready",  32'(in_ready),  32'(mq.size() < FIFO_DEPTH));
      check("gcd_start", 32'(gcd_start), 32'(exp_start));
      check("gcd_num_0", 32'(gcd_num_0), 32'(h0));
      check("gcd_num_1", 32'(gcd_num_1), 32'(h1));
      check("res_valid", 32'(res_valid), 32'(m_rv));
      check("res_gcd",   32'(res_gcd),   32'(m_rgcd));
      check("res_tag",   32'(res_tag),   32'(m_rtag));
      check("idle",      32'(idle),      32'(mq.size() == 0 && !m_inflight && !m_rv));
      if (reset === 1'b0 && res_valid === 1'b1 && res_ready === 1'b1) begin
        if (oq.size() == 0) begin
          check("order_unexpected_result", 32'(1), 32'(0));
        end else begin
          r = oq.pop_front();
          check("order_gcd", 32'(res_gcd), 32'(r.g));
          check("order_tag", 32'(res_tag), 32'(r.tag));
        end
      end
    end

    if (reset !== 1'b0) begin
      mq.delete();
      oq.delete();
      m_inflight = 1'b0;
      m_rv       = 1'b0;
      m_rgcd     = '0;
      m_rtag     = '0;
      m_atag     = '0;
    end else begin
      do_push = in_valid === 1'b1 && mq.size() < FIFO_DEPTH;
      if (m_inflight && gcd_done === 1'b1) begin
        m_rv       = 1'b1;
        m_rgcd     = gcd_result;
        m_rtag     = m_atag;
        m_inflight = 1'b0;
      end else if (m_rv && res_ready === 1'b1) begin
        m_rv = 1'b0;
      end
      if (exp_start) begin
        p          = mq.pop_front();
        m_atag     = p.tag;
        m_inflight = 1'b1;
      end
      if (do_push) begin
        p.a   = in_num_0;
        p.b   = in_num_1;
        p.tag = in_tag;
        mq.push_back(p);
        r.g   = ref_gcd(in_num_0, in_num_1);
        r.tag = in_tag;
        oq.push_back(r);
      end
    end

    if (gcd_start === 1'b1 && eng_left == 0) begin
      if (gcd_num_0 == '0 || gcd_num_1 == '0) lat = 1;
      else if (long_lat)                      lat = 8;
      else                                    lat = int'($urandom_range(1, 5));
      eng_left = lat;
      eng_res  = ref_gcd(gcd_num_0, gcd_num_1);
    end
    if (eng_left > 0) begin
      eng_busy_n = 1'b1;
      eng_done_n = (eng_left == 1);
      eng_res_n  = (eng_left == 1) ? eng_res : BIT_LEN'($urandom);
      eng_left--;
    end else if (stray_req) begin
      eng_busy_n = 1'b0;
      eng_done_n = 1'b1;
      eng_res_n  = 8'h55;
    end else begin
      eng_busy_n = 1'b0;
      eng_done_n = 1'b0;
      eng_res_n  = BIT_LEN'($urandom);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;

    repeat (3) tick();
    reset  = 1'b0;
    chk_en = 1'b1;
    @(negedge clk_i);
    check("rst_in_ready",  32'(in_ready),  32'(1));
    check("rst_gcd_start", 32'(gcd_start), 32'(0));
    check("rst_idle",      32'(idle),      32'(1));
    check("rst_res_valid", 32'(res_valid), 32'(0));
    check("rst_res_gcd",   32'(res_gcd),   32'(0));

    // Single job: start one cycle after the push, then one-cycle result 6/tag 3.
    tick();
    res_ready = 1'b1;
    set_in(1'b1, 8'd48, 8'd18, 4'd3);
    tick();
    set_in(1'b0, '0, '0, '0);
    @(negedge clk_i);
    check("t1_start", 32'(gcd_start), 32'(1));
    check("t1_num_0", 32'(gcd_num_0), 32'(48));
    check("t1_num_1", 32'(gcd_num_1), 32'(18));
    wait_res(20, ok);
    check("t1_res_seen", 32'(ok), 32'(1));
    check("t1_res_gcd",  32'(res_gcd), 32'(6));
    check("t1_res_tag",  32'(res_tag), 32'(3));
    tick();
    @(negedge clk_i);
    check("t1_res_one_cycle", 32'(res_valid), 32'(0));

    // Zero operands: result two cycles after start, in push order.
    tick();
    set_in(1'b1, 8'd0, 8'd0, 4'd1);
    tick();
    set_in(1'b1, 8'd0, 8'd25, 4'd2);
    @(negedge clk_i);
    check("t2_start", 32'(gcd_start), 32'(1));
    tick();
    set_in(1'b0, '0, '0, '0);
    @(negedge clk_i);
    check("t2_not_yet", 32'(res_valid), 32'(0));
    tick();
    @(negedge clk_i);
    check("t2_lat_valid", 32'(res_valid), 32'(1));
    check("t2_res0_gcd",  32'(res_gcd),   32'(0));
    check("t2_res0_tag",  32'(res_tag),   32'(1));
    tick();
    wait_res(20, ok);
    check("t2_res1_seen", 32'(ok), 32'(1));
    check("t2_res1_gcd",  32'(res_gcd), 32'(25));
    check("t2_res1_tag",  32'(res_tag), 32'(2));

    // Back-pressure: result held, second job waits for the slot.
    tick();
    res_ready = 1'b0;
    set_in(1'b1, 8'd12, 8'd8, 4'd5);
    tick();
    set_in(1'b1, 8'd7, 8'd7, 4'd6);
    tick();
    set_in(1'b0, '0, '0, '0);
    wait_res(20, ok);
    check("t3_res0_seen", 32'(ok), 32'(1));
    check("t3_res0_gcd",  32'(res_gcd), 32'(4));
    check("t3_res0_tag",  32'(res_tag), 32'(5));
    repeat (4) begin
      tick();
      @(negedge clk_i);
      check("t3_hold_valid", 32'(res_valid), 32'(1));
      check("t3_hold_gcd",   32'(res_gcd),   32'(4));
      check("t3_no_start",   32'(gcd_start), 32'(0));
    end
    tick();
    res_ready = 1'b1;
    @(negedge clk_i);
    check("t3_issue_on_accept", 32'(gcd_start), 32'(1));
    check("t3_issue_num_0",     32'(gcd_num_0), 32'(7));
    tick();
    wait_res(20, ok);
    check("t3_res1_seen", 32'(ok), 32'(1));
    check("t3_res1_gcd",  32'(res_gcd), 32'(7));
    check("t3_res1_tag",  32'(res_tag), 32'(6));

    // Fill the FIFO while the result slot is blocked.
    wait_idle(50, ok);
    check("t4_idle_before", 32'(ok), 32'(1));
    tick();
    res_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, BIT_LEN'($urandom_range(1, 255)), BIT_LEN'($urandom_range(1, 255)), TAG_W'(k + 8));
      tick();
    end
    set_in(1'b1, 8'd30, 8'd45, 4'd12);
    @(negedge clk_i);
    check("t4_room_for_5th", 32'(in_ready), 32'(1));
    tick();
    set_in(1'b1, 8'd81, 8'd27, 4'd13);
    @(negedge clk_i);
    check("t4_full", 32'(in_ready), 32'(0));
    repeat (10) begin
      tick();
      @(negedge clk_i);
      check("t4_full_held", 32'(in_ready), 32'(0));
    end
    tick();
    res_ready = 1'b1;
    @(negedge clk_i);
    check("t4_full_during_pop", 32'(in_ready),  32'(0));
    check("t4_pop_start",       32'(gcd_start), 32'(1));
    tick();
    @(negedge clk_i);
    check("t4_room_after_pop", 32'(in_ready), 32'(1));
    tick();
    set_in(1'b0, '0, '0, '0);
    wait_idle(300, ok);
    check("t4_drained", 32'(ok), 32'(1));

    // Reset while waiting on the engine; its later done is stray.
    tick();
    long_lat = 1'b1;
    set_in(1'b1, 8'd200, 8'd150, 4'd9);
    tick();
    set_in(1'b0, '0, '0, '0);
    @(negedge clk_i);
    check("t5_start", 32'(gcd_start), 32'(1));
    tick();
    long_lat = 1'b0;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk_i);
    check("t5_res_valid", 32'(res_valid), 32'(0));
    check("t5_in_ready",  32'(in_ready),  32'(1));
    check("t5_idle",      32'(idle),      32'(1));
    repeat (12) begin
      tick();
      @(negedge clk_i);
      check("t5_stray_ignored", 32'(res_valid), 32'(0));
    end

    // Stray done pulse while idle.
    tick();
    stray_req = 1'b1;
    tick();
    stray_req = 1'b0;
    @(negedge clk_i);
    check("t6_idle_during_stray", 32'(idle), 32'(1));
    tick();
    @(negedge clk_i);
    check("t6_no_result", 32'(res_valid), 32'(0));
    check("t6_idle_after", 32'(idle), 32'(1));

    // Random traffic with occasional resets.
    for (int c = 0; c < 500; c++) begin
      tick();
      in_valid  = ($urandom_range(0, 1) == 1);
      in_num_0  = ($urandom_range(0, 7) == 0) ? '0 : BIT_LEN'($urandom);
      in_num_1  = ($urandom_range(0, 7) == 0) ? '0 : BIT_LEN'($urandom);
      in_tag    = TAG_W'($urandom);
      res_ready = ($urandom_range(0, 9) < 7);
      reset     = ($urandom_range(0, 249) == 0);
    end
    tick();
    set_in(1'b0, '0, '0, '0);
    reset     = 1'b0;
    res_ready = 1'b1;
    wait_idle(400, ok);
    check("rand_drained", 32'(ok), 32'(1));
    check("rand_all_results_seen", 32'(oq.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
